// File: rtl/traffic_light_ctrl_pkg.sv
// rtl/traffic_light_ctrl_pkg.sv - shared state codes, lamp codes and display constants
package traffic_light_ctrl_pkg;

    // Phase encoding, in sequence order
    localparam logic [2:0] ST_NS_GREEN  = 3'd0;
    localparam logic [2:0] ST_NS_YELLOW = 3'd1;
    localparam logic [2:0] ST_ALL_RED1  = 3'd2;
    localparam logic [2:0] ST_EW_GREEN  = 3'd3;
    localparam logic [2:0] ST_EW_YELLOW = 3'd4;
    localparam logic [2:0] ST_ALL_RED2  = 3'd5;

    // Lamp codes {R,Y,G}, active-high
    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    // All segments off (active-low)
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic is_green(input logic [2:0] state);
        return (state == ST_NS_GREEN) || (state == ST_EW_GREEN);
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// rtl/traffic_light_ctrl_if.sv - strobe/request inputs and lamp/display outputs of the sequencer
interface traffic_light_ctrl_if;

    logic       tick_1hz;
    logic       tick_scan;
    logic       ped_req;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [6:0] seg;
    logic [1:0] an;
    logic       ped_pending;

    // Strobe source / board side
    modport master (
        output tick_1hz, tick_scan, ped_req,
        input  ns_light, ew_light, seg, an, ped_pending
    );

    // Sequencer side
    modport slave (
        input  tick_1hz, tick_scan, ped_req,
        output ns_light, ew_light, seg, an, ped_pending
    );

endinterface

// File: rtl/traffic_light_ctrl_bcd_to_seg7.sv
// rtl/traffic_light_ctrl_bcd_to_seg7.sv - 4-bit digit to active-low {g..a} pattern, >9 blanks
module bcd_to_seg7
    import traffic_light_ctrl_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    // Digit decode; anything outside 0..9 turns every segment off
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_digit)
            4'd0:    o_seg = 7'h40;
            4'd1:    o_seg = 7'h79;
            4'd2:    o_seg = 7'h24;
            4'd3:    o_seg = 7'h30;
            4'd4:    o_seg = 7'h19;
            4'd5:    o_seg = 7'h12;
            4'd6:    o_seg = 7'h02;
            4'd7:    o_seg = 7'h78;
            4'd8:    o_seg = 7'h00;
            4'd9:    o_seg = 7'h10;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - traffic-light sequencer with pedestrian shortening and 2-digit countdown
module traffic_light_ctrl
    import traffic_light_ctrl_pkg::*;
#(
    parameter int unsigned GREEN_S  = 15,
    parameter int unsigned YELLOW_S = 3,
    parameter int unsigned RED_S    = 1,
    parameter int unsigned PED_S    = 5
) (
    input  logic                 clk_50MHz,
    input  logic                 reset,
    traffic_light_ctrl_if.slave  bus
);

    localparam logic [6:0] L_GREEN    = 7'(GREEN_S);
    localparam logic [6:0] L_YELLOW   = 7'(YELLOW_S);
    localparam logic [6:0] L_RED      = 7'(RED_S);
    localparam logic [6:0] L_PED      = 7'(PED_S);
    localparam logic [3:0] L_RED_ONES = 4'(RED_S % 10);

    logic [2:0] r_state;
    logic [2:0] w_state_next;
    logic [6:0] r_cnt;
    logic [6:0] w_cnt_next;
    logic       r_ped_pending;
    logic       w_pend_next;
    logic       w_grant;
    logic       w_expire;
    logic [2:0] r_ns_light;
    logic [2:0] r_ew_light;
    logic [2:0] w_ns_light;
    logic [2:0] w_ew_light;
    logic       r_digit_sel;
    logic [6:0] r_seg;
    logic [1:0] r_an;
    logic [3:0] w_digit;
    logic [6:0] w_seg_digit;
    logic [6:0] w_seg_next;
    logic [1:0] w_an_next;
    logic [6:0] w_seg_reset;

    function automatic logic [6:0] phase_duration(input logic [2:0] state);
        case (state)
            ST_NS_GREEN, ST_EW_GREEN:   return L_GREEN;
            ST_NS_YELLOW, ST_EW_YELLOW: return L_YELLOW;
            default:                    return L_RED;
        endcase
    endfunction

    // A phase ends on the tick that finds the counter at 1; a grant needs more than PED_S left
    assign w_expire = bus.tick_1hz && (r_cnt == 7'd1);
    assign w_grant  = bus.tick_1hz && is_green(r_state) && r_ped_pending && (r_cnt > L_PED);

    // State register
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) r_state <= ST_ALL_RED2;
        else        r_state <= w_state_next;
    end

    // Next-state: advance around the fixed ring when the current phase expires
    always_comb begin
        w_state_next = r_state;
        if (w_expire) begin
            case (r_state)
                ST_NS_GREEN:  w_state_next = ST_NS_YELLOW;
                ST_NS_YELLOW: w_state_next = ST_ALL_RED1;
                ST_ALL_RED1:  w_state_next = ST_EW_GREEN;
                ST_EW_GREEN:  w_state_next = ST_EW_YELLOW;
                ST_EW_YELLOW: w_state_next = ST_ALL_RED2;
                default:      w_state_next = ST_NS_GREEN;
            endcase
        end
    end

    // Output decode: lamp pattern for the current phase, both red for anything unexpected
    always_comb begin
        w_ns_light = LAMP_R;
        w_ew_light = LAMP_R;
        case (r_state)
            ST_NS_GREEN:  w_ns_light = LAMP_G;
            ST_NS_YELLOW: w_ns_light = LAMP_Y;
            ST_EW_GREEN:  w_ew_light = LAMP_G;
            ST_EW_YELLOW: w_ew_light = LAMP_Y;
            default:      w_ns_light = LAMP_R;
        endcase
    end

    // Countdown and pedestrian latch next values; a grant beats a same-cycle request
    always_comb begin
        w_cnt_next  = r_cnt;
        w_pend_next = r_ped_pending;
        if (bus.tick_1hz) begin
            if (w_expire)     w_cnt_next = phase_duration(w_state_next);
            else if (w_grant) w_cnt_next = L_PED;
            else              w_cnt_next = r_cnt - 7'd1;
        end
        if (w_grant)                              w_pend_next = 1'b0;
        else if (bus.ped_req)                     w_pend_next = 1'b1;
        else if (w_expire && is_green(r_state))   w_pend_next = 1'b0;
    end

    // Registered lamps, counter, pedestrian latch and scan phase
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            r_ns_light    <= LAMP_R;
            r_ew_light    <= LAMP_R;
            r_cnt         <= L_RED;
            r_ped_pending <= 1'b0;
            r_digit_sel   <= 1'b0;
        end else begin
            r_ns_light    <= w_ns_light;
            r_ew_light    <= w_ew_light;
            r_cnt         <= w_cnt_next;
            r_ped_pending <= w_pend_next;
            if (bus.tick_scan) r_digit_sel <= ~r_digit_sel;
        end
    end

    // Pick the digit for the active scan phase; leading zero of the tens digit is blanked
    always_comb begin
        w_digit    = r_digit_sel ? 4'(r_cnt / 7'd10) : 4'(r_cnt % 7'd10);
        w_seg_next = (r_digit_sel && (r_cnt < 7'd10)) ? SEG_BLANK : w_seg_digit;
        w_an_next  = r_digit_sel ? 2'b01 : 2'b10;
    end

    bcd_to_seg7 u_digit_seg (
        .i_digit (w_digit),
        .o_seg   (w_seg_digit)
    );

    bcd_to_seg7 u_reset_seg (
        .i_digit (L_RED_ONES),
        .o_seg   (w_seg_reset)
    );

    // seg and an share one register stage so the digit and its enable always agree
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            r_seg <= w_seg_reset;
            r_an  <= 2'b10;
        end else begin
            r_seg <= w_seg_next;
            r_an  <= w_an_next;
        end
    end

    assign bus.ns_light    = r_ns_light;
    assign bus.ew_light    = r_ew_light;
    assign bus.seg         = r_seg;
    assign bus.an          = r_an;
    assign bus.ped_pending = r_ped_pending;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb/tb_traffic_light_ctrl.sv - vector table, corner sequences and random run against a phase-table model
module tb_traffic_light_ctrl;

    localparam int GREEN_S  = 15;
    localparam int YELLOW_S = 3;
    localparam int RED_S    = 1;
    localparam int PED_S    = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    traffic_light_ctrl_if tl_if ();

    traffic_light_ctrl #(
        .GREEN_S  (GREEN_S),
        .YELLOW_S (YELLOW_S),
        .RED_S    (RED_S),
        .PED_S    (PED_S)
    ) dut (
        .clk_50MHz (clk),
        .reset     (rst_n),
        .bus       (tl_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Phase ring: 0 NS green, 1 NS yellow, 2 all red, 3 EW green, 4 EW yellow, 5 all red
    int         dur    [6] = '{GREEN_S, YELLOW_S, RED_S, GREEN_S, YELLOW_S, RED_S};
    logic [2:0] ns_tab [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] ew_tab [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [6:0] seg_tab[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    int         m_phase;
    int         m_cnt;
    bit         m_pend;
    bit         m_dsel;
    logic [2:0] m_ns, m_ew;
    logic [6:0] m_seg;
    logic [1:0] m_an;

    typedef struct {
        bit         t1;
        bit         ped;
        int         cnt;
        logic [2:0] ns;
        logic [2:0] ew;
        bit         pend;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 5;
        m_cnt   = RED_S;
        m_pend  = 0;
        m_dsel  = 0;
        m_ns    = 3'b100;
        m_ew    = 3'b100;
        m_an    = 2'b10;
        m_seg   = seg_tab[RED_S % 10];
    endtask

    task automatic model_step(input bit t1, input bit ts, input bit pr);
        bit green, grant, expire;
        m_ns  = ns_tab[m_phase];
        m_ew  = ew_tab[m_phase];
        m_an  = m_dsel ? 2'b01 : 2'b10;
        if (m_dsel && m_cnt < 10) m_seg = 7'h7F;
        else                      m_seg = seg_tab[m_dsel ? m_cnt / 10 : m_cnt % 10];
        green  = (m_phase == 0) || (m_phase == 3);
        grant  = t1 && green && m_pend && (m_cnt > PED_S);
        expire = t1 && (m_cnt == 1);
        if (grant)                m_pend = 0;
        else if (pr)              m_pend = 1;
        else if (expire && green) m_pend = 0;
        if (t1) begin
            if (m_cnt == 1) begin
                m_phase = (m_phase + 1) % 6;
                m_cnt   = dur[m_phase];
            end else if (grant) begin
                m_cnt = PED_S;
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
        if (ts) m_dsel = !m_dsel;
    endtask

    task automatic check_model();
        check("model_ns",   tl_if.ns_light,    m_ns);
        check("model_ew",   tl_if.ew_light,    m_ew);
        check("model_seg",  tl_if.seg,         m_seg);
        check("model_an",   tl_if.an,          m_an);
        check("model_pend", tl_if.ped_pending, m_pend);
        check("model_cnt",  dut.r_cnt,         m_cnt);
    endtask

    task automatic cycle(input bit t1, input bit ts, input bit pr);
        @(negedge clk);
        tl_if.tick_1hz  = t1;
        tl_if.tick_scan = ts;
        tl_if.ped_req   = pr;
        @(posedge clk);
        model_step(t1, ts, pr);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n           = 1'b0;
        tl_if.tick_1hz  = 1'b0;
        tl_if.tick_scan = 1'b0;
        tl_if.ped_req   = 1'b0;
        model_reset();
        #1;
        check("rst_ns",   tl_if.ns_light,    3'b100);
        check("rst_ew",   tl_if.ew_light,    3'b100);
        check("rst_an",   tl_if.an,          2'b10);
        check("rst_seg",  tl_if.seg,         seg_tab[RED_S % 10]);
        check("rst_pend", tl_if.ped_pending, 1'b0);
        check("rst_cnt",  dut.r_cnt,         RED_S);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [5:0] seen[$];
        logic [5:0] want[$];
        logic [5:0] last;
        bit         both_green;

        tl_if.tick_1hz  = 1'b0;
        tl_if.tick_scan = 1'b0;
        tl_if.ped_req   = 1'b0;
        do_reset();

        // Table: one stimulus cycle then one idle cycle, then lamps/counter/latch
        vecs.push_back(vec_t'{1, 0, 15, 3'b001, 3'b100, 0});
        vecs.push_back(vec_t'{1, 0, 14, 3'b001, 3'b100, 0});
        vecs.push_back(vec_t'{1, 0, 13, 3'b001, 3'b100, 0});
        vecs.push_back(vec_t'{1, 0, 12, 3'b001, 3'b100, 0});
        vecs.push_back(vec_t'{0, 1, 12, 3'b001, 3'b100, 1});
        vecs.push_back(vec_t'{1, 0,  5, 3'b001, 3'b100, 0});
        vecs.push_back(vec_t'{1, 0,  4, 3'b001, 3'b100, 0});
        vecs.push_back(vec_t'{0, 1,  4, 3'b001, 3'b100, 1});
        vecs.push_back(vec_t'{1, 0,  3, 3'b001, 3'b100, 1});
        vecs.push_back(vec_t'{1, 0,  2, 3'b001, 3'b100, 1});
        vecs.push_back(vec_t'{1, 0,  1, 3'b001, 3'b100, 1});
        vecs.push_back(vec_t'{1, 0,  3, 3'b010, 3'b100, 0});
        vecs.push_back(vec_t'{0, 1,  3, 3'b010, 3'b100, 1});
        vecs.push_back(vec_t'{1, 0,  2, 3'b010, 3'b100, 1});
        vecs.push_back(vec_t'{1, 0,  1, 3'b010, 3'b100, 1});
        vecs.push_back(vec_t'{1, 0,  1, 3'b100, 3'b100, 1});
        vecs.push_back(vec_t'{1, 0, 15, 3'b100, 3'b001, 1});
        vecs.push_back(vec_t'{1, 0,  5, 3'b100, 3'b001, 0});
        vecs.push_back(vec_t'{1, 0,  4, 3'b100, 3'b001, 0});
        foreach (vecs[i]) begin
            cycle(vecs[i].t1, 1'b0, vecs[i].ped);
            cycle(1'b0, 1'b0, 1'b0);
            check($sformatf("tbl%0d_cnt", i),  dut.r_cnt,         vecs[i].cnt);
            check($sformatf("tbl%0d_ns", i),   tl_if.ns_light,    vecs[i].ns);
            check($sformatf("tbl%0d_ew", i),   tl_if.ew_light,    vecs[i].ew);
            check($sformatf("tbl%0d_pend", i), tl_if.ped_pending, vecs[i].pend);
        end

        // Full 38-tick ring from NS green entry
        do_reset();
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        last       = {tl_if.ns_light, tl_if.ew_light};
        both_green = 0;
        want = '{6'b010_100, 6'b100_100, 6'b100_001, 6'b100_010, 6'b100_100, 6'b001_100};
        for (int t = 0; t < 38; t++) begin
            cycle(1'b1, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 1'b0);
            if (tl_if.ns_light[0] && tl_if.ew_light[0]) both_green = 1;
            if ({tl_if.ns_light, tl_if.ew_light} != last) begin
                last = {tl_if.ns_light, tl_if.ew_light};
                seen.push_back(last);
            end
        end
        check("ring_both_green", both_green, 1'b0);
        check("ring_n_changes", seen.size(), want.size());
        for (int k = 0; k < 6 && k < seen.size(); k++)
            check($sformatf("ring_change%0d", k), seen[k], want[k]);
        check("ring_cnt", dut.r_cnt, 15);
        check("ring_ns",  tl_if.ns_light, 3'b001);

        // Display scan at cnt=15, then tens blanking at cnt=3
        check("scan15_an0",  tl_if.an,  2'b10);
        check("scan15_seg0", tl_if.seg, 7'h12);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("scan15_an1",  tl_if.an,  2'b01);
        check("scan15_seg1", tl_if.seg, 7'h79);
        for (int t = 0; t < 12; t++) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("scan3_an1",  tl_if.an,  2'b01);
        check("scan3_seg1", tl_if.seg, 7'h7F);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("scan3_an0",  tl_if.an,  2'b10);
        check("scan3_seg0", tl_if.seg, 7'h30);

        // All three strobes together at cnt=9 with a request already latched
        do_reset();
        for (int t = 0; t < 7; t++) cycle(1'b1, 1'b0, 1'b0);
        check("sim_cnt9", dut.r_cnt, 9);
        cycle(1'b0, 1'b0, 1'b1);
        check("sim_pend_set", tl_if.ped_pending, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        check("sim_grant_cnt",  dut.r_cnt, PED_S);
        check("sim_grant_pend", tl_if.ped_pending, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        check("sim_relatch", tl_if.ped_pending, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        check("sim_an_toggled", tl_if.an,  2'b01);
        check("sim_seg_blank",  tl_if.seg, 7'h7F);
        for (int t = 0; t < 11; t++) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("mid_ew_green", tl_if.ew_light, 3'b001);
        check("mid_ew_cnt",   dut.r_cnt, 13);

        // Asynchronous reset between clock edges
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_ns",   tl_if.ns_light,    3'b100);
        check("async_ew",   tl_if.ew_light,    3'b100);
        check("async_cnt",  dut.r_cnt,         RED_S);
        check("async_pend", tl_if.ped_pending, 1'b0);
        check("async_an",   tl_if.an,          2'b10);
        @(negedge clk);
        rst_n = 1'b1;

        // Random strobes and requests against the model
        for (int c = 0; c < 3000; c++)
            cycle($urandom_range(2) == 0, $urandom_range(1) == 0, $urandom_range(9) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
- Consumer side of the divider's slow-timing outputs: a single-clock traffic-light sequencer on clk_50MHz.
- Advances on 1 Hz single-cycle enable strobes and refreshes a 2-digit multiplexed 7-segment countdown on scan strobes.
- Sits between the frequency divider (strobe source) and board I/O (lamps, 7-seg).
- Handles a latched pedestrian request that shortens the current green phase.

Parameters:
- GREEN_S, 15, green duration in seconds (1..99)
- YELLOW_S, 3, yellow duration in seconds (1..99)
- RED_S, 1, all-red clearance in seconds (1..99)
- PED_S, 5, green remaining after a granted pedestrian request (1..GREEN_S)

Ports:
- clk_50MHz  input  1  system clock
- reset  input  1  asynchronous active-low reset
- tick_1hz  input  1  one-cycle enable, 1 pulse/s, synchronous to clk_50MHz
- tick_scan  input  1  one-cycle enable, digit-scan rate, synchronous to clk_50MHz
- ped_req  input  1  pedestrian button, level, already debounced/synchronous
- ns_light  output  3  {R,Y,G} north-south lamps, active-high
- ew_light  output  3  {R,Y,G} east-west lamps, active-high
- seg  output  7  segments {g..a}, active-low
- an  output  2  digit enables, active-low; an[0]=ones, an[1]=tens
- ped_pending  output  1  request latched, not yet serviced

Behaviour:
- Reset (asynchronous, active-low; all registers):
  - state=ALL_RED2, cnt=RED_S, ped_pending=0.
  - ns_light=ew_light=3'b100.
  - an=2'b10, digit_sel=0.
  - seg shows ones digit of RED_S.
- States and sequence: NS_GREEN -> NS_YELLOW -> ALL_RED1 -> EW_GREEN -> EW_YELLOW -> ALL_RED2 -> NS_GREEN.
- Lamps (registered, change in the cycle after the state change):
  - NS_GREEN: ns=001, ew=100
  - NS_YELLOW: ns=010, ew=100
  - ALL_RED1/2: ns=100, ew=100
  - EW_GREEN: ns=100, ew=001
  - EW_YELLOW: ns=100, ew=010
- Countdown cnt, 7 bits:
  - Changes only on a cycle with tick_1hz=1.
  - cnt==1 on tick: go to the next state and load that state's duration.
  - Otherwise on tick: cnt <= cnt-1.
  - cnt never reads 0.
- Pedestrian request:
  - ped_req=1 sets ped_pending on the next edge, in any state.
  - In a green state, on a tick with ped_pending=1 and cnt>PED_S: cnt <= PED_S instead of decrementing, and ped_pending clears.
  - In a green state, on a tick with ped_pending=1 and cnt<=PED_S: normal decrement; pending clears when the green state exits.
  - In non-green states, pending is held until the next green.
  - ped_req and a granting tick in the same cycle: grant wins and pending ends at 0. A ped_req still high afterwards re-latches next cycle.
- Display:
  - digit_sel toggles on each tick_scan.
  - an=2'b10 shows cnt%10; an=2'b01 shows cnt/10.
  - Tens digit is blanked (seg=7'h7F) when cnt<10.
  - seg and an are registered together, so they never show a mismatched digit.
  - Binary-to-BCD is done on cnt directly (cnt<=99).
- Simultaneous tick_1hz and tick_scan: both take effect in the same cycle. The display uses the updated cnt one cycle later at most.
- No strobes: all state holds indefinitely.
- Reset mid-phase: immediate return to the reset values above.

Decomposition:
- Shared package contents:
  - State encoding (3-bit localparams).
  - Lamp codes LAMP_R=3'b100, LAMP_Y=3'b010, LAMP_G=3'b001.
  - Seg constant for blank.
- One sub-module: bcd_to_seg7. Combinational, 4-bit digit -> 7-bit active-low pattern; values >9 give blank.
- FSM, counter, pedestrian latch and scan mux stay in traffic_light_ctrl.

Test Plan:
- Reset, then 1 tick_1hz -> state NS_GREEN, cnt=15, ns=001, ew=100.
- Full cycle, 15+3+1+15+3+1=38 ticks from NS_GREEN entry -> back in NS_GREEN, cnt=15; every lamp pattern seen in order, never green on both.
- ped_req pulse at cnt=12 in NS_GREEN, then a tick -> cnt=5, ped_pending 1->0. Pulse at cnt=4 -> normal decrement, pending clears on NS_YELLOW entry.
- ped_req during NS_YELLOW -> pending held through ALL_RED1; first tick in EW_GREEN loads cnt=5.
- Scan with cnt=15 -> an=10 seg=digit5, then an=01 seg=digit1. With cnt=3 -> tens phase seg=7F.
- tick_1hz, tick_scan and ped_req all in one cycle at NS_GREEN cnt=9; then reset asserted mid-EW_GREEN -> cnt=5, pending=0, digit toggled; reset gives both red, cnt=RED_S asynchronously.
